// File: rtl/fetch_stage_pkg.sv
// Shared pipeline types: fetch FSM states, NOP encoding and the IF/ID record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // no request outstanding
    WAIT  = 2'd1,  // one request outstanding
    HOLD  = 2'd2   // skid buffer full, waiting for decode to accept
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // IF/ID pipeline record, also consumed by the decode stage.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding a fetched word while decode is stalled.
// Latency: loaded word visible the cycle after load_i.
// Backpressure: none of its own; the fetch FSM never loads it while full.
//
// Ports: clk/rst (async active-high); load_i captures instr_i/pc4_i;
// drain_i and clear_i empty the entry (clear_i wins over load_i);
// valid_o/instr_o/pc4_o expose the held entry.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc4_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc4_o
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (clear_i || drain_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc4_d   = pc4_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc4_o   = pc4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and one-entry skid buffer.
// Latency: request accepted in cycle N, data in N+1, IF/ID valid in N+2.
// Backpressure: stall_i holds IF/ID; a word returning under stall parks in the skid.
//
// Ports: clk, rst (async active-high); stall_i/redirect_i/redirect_pc_i from
// decode/execute; imem_req_o/imem_addr_o/imem_ready_i request channel;
// imem_rvalid_i/imem_rdata_i in-order response (max one outstanding);
// if_id_valid_o/if_id_instr_o/if_id_pc4_o to decode.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched_o and perf_bubbles_o.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_bubbles_o
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         drop_q, drop_d;
  if_id_t       if_id_q, if_id_d;
  logic         req_c;

  logic         skid_load, skid_drain, skid_clear, skid_valid;
  logic [31:0]  skid_instr, skid_pc4;

  // Target alignment bits are intentionally dropped.
  logic         unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .clear_i (skid_clear),
    .instr_i (imem_rdata_i),
    .pc4_i   (req_pc_q + 32'd4),
    .valid_o (skid_valid),
    .instr_o (skid_instr),
    .pc4_o   (skid_pc4)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    if_id_d    = if_id_q;
    req_c      = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;

    // With decode accepting, IF/ID becomes a bubble unless a word lands below.
    // A bubble keeps instr/pc4 so only valid toggles.
    if (!stall_i) if_id_d.valid = 1'b0;

    unique case (state_q)
      FETCH: begin
        req_c = 1'b1;
        if (imem_ready_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = FETCH;
          end else if (!stall_i) begin
            if_id_d = '{valid: 1'b1, instr: imem_rdata_i, pc4: req_pc_q + 32'd4};
            // Chained issue keeps one word per cycle in steady state.
            req_c = 1'b1;
            if (imem_ready_i) begin
              req_pc_d = pc_q;
              pc_d     = pc_q + 32'd4;
            end else begin
              state_d = FETCH;
            end
          end else begin
            skid_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall_i) begin
          if_id_d    = '{valid: skid_valid, instr: skid_instr, pc4: skid_pc4};
          skid_drain = 1'b1;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // Redirect overrides everything decided above.
    if (redirect_i) begin
      pc_d          = {redirect_pc_i[31:2], 2'b00};
      if_id_d.valid = 1'b0;
      skid_clear    = 1'b1;
      skid_load     = 1'b0;
      skid_drain    = 1'b0;
      req_c         = 1'b0;
      req_pc_d      = req_pc_q;
      if (state_q == WAIT && !imem_rvalid_i) begin
        // The in-flight word still has to come back; swallow it.
        drop_d  = 1'b1;
        state_d = WAIT;
      end else begin
        drop_d  = 1'b0;
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      drop_q   <= 1'b0;
      if_id_q  <= '{valid: 1'b0, instr: NOP_INSTR, pc4: 32'h0};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
      if_id_q  <= if_id_d;
    end
  end

  // No request is presented while reset is held.
  assign imem_req_o    = req_c & ~rst;
  assign imem_addr_o   = pc_q;
  assign if_id_valid_o = if_id_q.valid;
  assign if_id_instr_o = if_id_q.instr;
  assign if_id_pc4_o   = if_id_q.pc4;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_bubbles_q;
  logic        if_id_we;

  // IF/ID is written whenever decode accepts or a redirect flushes it.
  assign if_id_we = redirect_i | ~stall_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched_q <= 32'h0;
      perf_bubbles_q <= 32'h0;
    end else if (if_id_we) begin
      if (if_id_d.valid) perf_fetched_q <= perf_fetched_q + 32'd1;
      else               perf_bubbles_q <= perf_bubbles_q + 32'd1;
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_bubbles_o = perf_bubbles_q;
`else
  // Counters are not built in this configuration.
`endif

endmodule
